// File: rtl/prog_seq_det.sv
// rtl/prog_seq_det.sv - programmable serial sequence detector
//
// Ports:
//   clk        rising-edge clock
//   rst        asynchronous active-low reset
//   in         serial data bit
//   in_valid   qualifies in for sampling
//   load       configuration strobe (takes priority over in_valid)
//   pat        pattern, pat[pat_len-1] first expected bit, pat[0] last
//   pat_len    pattern length, legal 1..MAX_LEN
//   overlap    1 = overlapping detection, 0 = non-overlapping
//   out        registered one-cycle match pulse
//   match_cnt  saturating match count
//   armed      high while a legal configuration is held
//
// Macro SEQ_DET_CNT_EN: when defined, match_cnt is a saturating counter;
// otherwise match_cnt is tied to zero and no counter flops exist.

module prog_seq_det #(
  parameter int MAX_LEN = 16,
  parameter int LEN_W   = 5,
  parameter int CNT_W   = 8
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               in,
  input  logic               in_valid,
  input  logic               load,
  input  logic [MAX_LEN-1:0] pat,
  input  logic [LEN_W-1:0]   pat_len,
  input  logic               overlap,
  output logic               out,
  output logic [CNT_W-1:0]   match_cnt,
  output logic               armed
);

  typedef enum logic [1:0] {IDLE, FILL, DETECT} state_t;

  state_t             state;
  logic [MAX_LEN-1:0] cfg_pat;
  logic [LEN_W-1:0]   cfg_len;
  logic               cfg_ovl;
  // Previously sampled bits; together with the incoming bit they form the
  // MAX_LEN-bit history window, which lets a match be flagged on the very
  // edge that samples its last bit.
  logic [MAX_LEN-2:0] prev;
  logic [LEN_W-1:0]   fill;

  logic               len_ok;
  logic               load_ok;
  logic               sample;
  logic               hit;
  logic [MAX_LEN-1:0] window;
  logic [MAX_LEN-1:0] mask;
  logic [LEN_W-1:0]   fill_nxt;

  always_comb begin
    len_ok   = (pat_len != '0) && (pat_len <= LEN_W'(MAX_LEN));
    load_ok  = load && len_ok;
    // An illegal strobe is ignored entirely, so it does not block a sample.
    sample   = (state != IDLE) && in_valid && !load_ok;
    window   = {prev, in};
    fill_nxt = (fill == LEN_W'(MAX_LEN)) ? fill : fill + LEN_W'(1);
    mask     = '0;
    for (int i = 0; i < MAX_LEN; i++) begin
      mask[i] = (LEN_W'(i) < cfg_len);
    end
    // Only compare once enough fresh bits are held; after a non-overlapping
    // match the fill count restarts so no bit is reused.
    hit = sample && (fill_nxt >= cfg_len) && (((window ^ cfg_pat) & mask) == '0);
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state   <= IDLE;
      cfg_pat <= '0;
      cfg_len <= '0;
      cfg_ovl <= 1'b0;
      prev    <= '0;
      fill    <= '0;
      out     <= 1'b0;
      armed   <= 1'b0;
    end else if (load_ok) begin
      state   <= FILL;
      cfg_pat <= pat;
      cfg_len <= pat_len;
      cfg_ovl <= overlap;
      prev    <= '0;
      fill    <= '0;
      out     <= 1'b0;
      armed   <= 1'b1;
    end else begin
      out <= hit;
      if (sample) begin
        prev <= window[MAX_LEN-2:0];
        if (hit && !cfg_ovl) begin
          fill  <= '0;
          state <= FILL;
        end else begin
          fill <= fill_nxt;
          if (fill_nxt >= cfg_len) begin
            state <= DETECT;
          end
        end
      end
    end
  end

`ifdef SEQ_DET_CNT_EN
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      match_cnt <= '0;
    end else if (load_ok) begin
      match_cnt <= '0;
    end else if (hit && (match_cnt != '1)) begin
      match_cnt <= match_cnt + CNT_W'(1);
    end
  end
`else
  assign match_cnt = '0;
`endif

endmodule

// File: tb/tb_prog_seq_det.sv
// tb/tb_prog_seq_det.sv - scoreboard bench for prog_seq_det

module tb_prog_seq_det;

`ifdef SEQ_DET_CNT_EN
  localparam bit CNT_EN = 1'b1;
`else
  localparam bit CNT_EN = 1'b0;
`endif

  logic        clk;
  logic        rst;
  logic        in;
  logic        in_valid;
  logic        load;
  logic [15:0] pat;
  logic [4:0]  pat_len;
  logic        overlap;
  logic        out;
  logic [1:0]  match_cnt;
  logic        armed;

  prog_seq_det #(.MAX_LEN(16), .LEN_W(5), .CNT_W(2)) dut (
    .clk(clk), .rst(rst), .in(in), .in_valid(in_valid), .load(load),
    .pat(pat), .pat_len(pat_len), .overlap(overlap), .out(out),
    .match_cnt(match_cnt), .armed(armed)
  );

  typedef struct {
    logic       o;
    logic       a;
    logic [1:0] c;
    string      nm;
  } exp_t;

  exp_t q[$];
  int checks = 0;
  int errors = 0;
  logic       mdl_armed = 1'b0;
  logic [1:0] mdl_cnt = 2'd0;

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string nm, input int got, input int want);
    checks++;
    if (got != want) begin
      errors++;
      $display("FAIL %s got %0d want %0d", nm, got, want);
    end
  endtask

  // Monitor: one expectation per driven cycle, compared just after the edge.
  initial begin
    exp_t e;
    forever begin
      @(posedge clk);
      #1;
      if (q.size() > 0) begin
        e = q.pop_front();
        chk({e.nm, ".out"}, int'(out), int'(e.o));
        chk({e.nm, ".armed"}, int'(armed), int'(e.a));
        chk({e.nm, ".cnt"}, int'(match_cnt), int'(e.c));
      end
    end
  end

  task automatic drive(input logic r, input logic ld, input logic [15:0] p,
                       input logic [4:0] l, input logic ov, input logic v,
                       input logic i, input logic eo, input string nm);
    exp_t e;
    @(negedge clk);
    rst = r; load = ld; pat = p; pat_len = l; overlap = ov;
    in_valid = v; in = i;
    e.o = eo;
    e.a = mdl_armed;
    e.c = CNT_EN ? mdl_cnt : 2'd0;
    e.nm = nm;
    q.push_back(e);
  endtask

  task automatic do_load(input logic [15:0] p, input logic [4:0] l, input logic ov,
                         input logic legal, input logic v, input logic i,
                         input string nm);
    if (legal) begin
      mdl_armed = 1'b1;
      mdl_cnt = 2'd0;
    end
    drive(1'b1, 1'b1, p, l, ov, v, i, 1'b0, nm);
  endtask

  task automatic do_bit(input logic v, input logic i, input logic eo, input string nm);
    if (eo && mdl_cnt != 2'd3) mdl_cnt = mdl_cnt + 2'd1;
    drive(1'b1, 1'b0, 16'h0, 5'd0, 1'b0, v, i, eo, nm);
  endtask

  task automatic do_rst(input string nm);
    mdl_armed = 1'b0;
    mdl_cnt = 2'd0;
    drive(1'b0, 1'b0, 16'h0, 5'd0, 1'b0, 1'b0, 1'b0, 1'b0, nm);
  endtask

  // Streams n bits of bits (MSB first) with hand-computed out pulses in outs.
  task automatic stream(input logic [31:0] bits, input int n, input logic [31:0] outs,
                        input string nm);
    for (int k = n - 1; k >= 0; k--) begin
      do_bit(1'b1, bits[k], outs[k], $sformatf("%s[%0d]", nm, n - 1 - k));
    end
  endtask

  initial begin
    int w;
    rst = 1'b1; load = 1'b0; pat = '0; pat_len = '0; overlap = 1'b0;
    in_valid = 1'b0; in = 1'b0;
    #1 rst = 1'b0;
    #1;
    chk("reset.out", int'(out), 0);
    chk("reset.armed", int'(armed), 0);
    chk("reset.cnt", int'(match_cnt), 0);
    do_rst("rst_hold");

    // Illegal length from IDLE: stays unarmed, no detection.
    do_load(16'h000B, 5'd0, 1'b1, 1'b0, 1'b0, 1'b0, "ld_len0");
    stream(32'b1011, 4, 32'b0000, "len0");

    // Overlapping 1011.
    do_load(16'h000B, 5'd4, 1'b1, 1'b1, 1'b0, 1'b0, "ld_ovl");
    stream(32'b1011011, 7, 32'b0001001, "ovl");

    // Illegal length while armed: config, history and count retained.
    do_load(16'h0000, 5'd17, 1'b0, 1'b0, 1'b0, 1'b0, "ld_len17");
    stream(32'b011, 3, 32'b001, "post_illegal");

    // Non-overlapping 1011, upper pattern bits set and ignored.
    do_load(16'hFFFB, 5'd4, 1'b0, 1'b1, 1'b0, 1'b0, "ld_novl");
    stream(32'b10110111011, 11, 32'b00010000001, "novl");

    // in_valid toggling; invalid cycles carry junk and must give out=0.
    do_load(16'h000B, 5'd4, 1'b1, 1'b1, 1'b0, 1'b0, "ld_gap");
    do_bit(1'b1, 1'b1, 1'b0, "gap_v0");
    do_bit(1'b0, 1'b1, 1'b0, "gap_i0");
    do_bit(1'b1, 1'b0, 1'b0, "gap_v1");
    do_bit(1'b0, 1'b1, 1'b0, "gap_i1");
    do_bit(1'b1, 1'b1, 1'b0, "gap_v2");
    do_bit(1'b0, 1'b0, 1'b0, "gap_i2");
    do_bit(1'b1, 1'b1, 1'b1, "gap_v3");
    do_bit(1'b0, 1'b1, 1'b0, "gap_i3");

    // Load with a simultaneous valid sample: the sample is discarded.
    do_load(16'h000B, 5'd4, 1'b1, 1'b1, 1'b1, 1'b1, "ld_prio");
    stream(32'b011, 3, 32'b000, "prio");

    // Reset mid-pattern, then reload.
    do_load(16'h000B, 5'd4, 1'b1, 1'b1, 1'b0, 1'b0, "ld_pre_rst");
    stream(32'b101, 3, 32'b000, "pre_rst");
    do_rst("mid_rst");
    do_bit(1'b1, 1'b1, 1'b0, "idle_sample");
    do_load(16'h000B, 5'd4, 1'b1, 1'b1, 1'b0, 1'b0, "ld_post_rst");
    stream(32'b1011, 4, 32'b0001, "post_rst");

    // Maximum length pattern.
    do_load(16'hA5A5, 5'd16, 1'b1, 1'b1, 1'b0, 1'b0, "ld_len16");
    stream(32'h0000A5A5, 16, 32'h00000001, "len16");

    // Length 1, non-overlapping, counter saturation.
    do_load(16'hA5A5, 5'd1, 1'b0, 1'b1, 1'b0, 1'b0, "ld_len1");
    stream(32'b11111, 5, 32'b11111, "len1_sat");
    do_bit(1'b1, 1'b0, 1'b0, "len1_zero");
    do_bit(1'b0, 1'b1, 1'b0, "len1_idle");

    // Length 1, overlapping, pattern bit 0.
    do_load(16'h5A5A, 5'd1, 1'b1, 1'b1, 1'b0, 1'b0, "ld_len1_ovl");
    stream(32'b010, 3, 32'b101, "len1_ovl");

    w = 0;
    while (q.size() != 0 && w < 10) begin
      @(posedge clk);
      w++;
    end
    #2;
    checks++;
    if (q.size() != 0) begin
      errors++;
      $display("FAIL drain got %0d pending want 0", q.size());
    end
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
